// File: rtl/sd_img_responder.sv
// sd_img_responder
//   Block-device responder for the FDC sector interface. Accepts per-drive
//   sd_rd/sd_wr level requests, opens an sd_ack window and streams one
//   512-byte sector between the controller's sector buffer (sd_buff_*) and a
//   byte-wide image memory (mem_*).
//
// Parameters:
//   IMG_BASE0 / IMG_BASE1 : byte base address of the drive 0 / drive 1 image
//
// Ports:
//   clk_sys, reset_n          : clock, synchronous active-low reset
//   img_size0/1 [31:0]        : image size in bytes per drive
//   sd_lba [31:0]             : sector number, sampled at accept
//   sd_rd/sd_wr [1:0]         : per-drive read/write request levels
//   sd_ack                    : transfer window
//   sd_buff_addr [8:0]        : byte index within the sector
//   sd_buff_dout [7:0]        : read data to the controller, sd_buff_wr strobe
//   sd_buff_din [7:0]         : write data, valid one cycle after the address
//   mem_req/mem_we/mem_addr/mem_wdata, mem_ack/mem_rdata : image memory
//   busy                      : not idle
//   range_err                 : one-cycle pulse ending an out-of-range transfer
//
// Build option:
//   SDRESP_WRITE_EN : when defined, write transfers store into image memory;
//   otherwise writes are walked and discarded and always flag range_err.
module sd_img_responder #(
  parameter logic [31:0] IMG_BASE0 = 32'h0000_0000,
  parameter logic [31:0] IMG_BASE1 = 32'h0010_0000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [31:0] img_size0,
  input  logic [31:0] img_size1,
  input  logic [31:0] sd_lba,
  input  logic [1:0]  sd_rd,
  input  logic [1:0]  sd_wr,
  output logic        sd_ack,
  output logic [8:0]  sd_buff_addr,
  output logic [7:0]  sd_buff_dout,
  output logic        sd_buff_wr,
  input  logic [7:0]  sd_buff_din,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        range_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_RFETCH, S_RPUSH, S_WADDR, S_WCAP, S_WSTORE, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;
  logic [31:0] secbase_q, secbase_d;
  logic        oor_q, oor_d;

  logic        acc_req, acc_drv, acc_wr, acc_oor, last;
  logic [31:0] size_sel, base_sel;
  logic        unused_size_lsbs;

  // Request arbitration: rd0, wr0, rd1, wr1.
  always_comb begin
    acc_req  = (|sd_rd) | (|sd_wr);
    acc_drv  = !(sd_rd[0] | sd_wr[0]);
    acc_wr   = acc_drv ? !sd_rd[1] : !sd_rd[0];
    size_sel = acc_drv ? img_size1 : img_size0;
    base_sel = acc_drv ? IMG_BASE1 : IMG_BASE0;
    acc_oor  = sd_lba >= {9'd0, size_sel[31:9]};
`ifndef SDRESP_WRITE_EN
    if (acc_wr) acc_oor = 1'b1;
`endif
    unused_size_lsbs = ^size_sel[8:0];
    last = (cnt_q == 9'd511);
  end

  // Drive and LBA are folded into one sector base address at accept.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    secbase_d = secbase_q;
    oor_d     = oor_q;
    case (state_q)
      S_IDLE: begin
        if (acc_req) begin
          cnt_d     = '0;
          data_d    = '0;
          oor_d     = acc_oor;
          secbase_d = base_sel + {sd_lba[22:0], 9'd0};
          state_d   = acc_wr ? S_WADDR : (acc_oor ? S_RPUSH : S_RFETCH);
        end
      end
      S_RFETCH: begin
        if (mem_ack) begin
          data_d  = mem_rdata;
          state_d = S_RPUSH;
        end
      end
      S_RPUSH: begin
        cnt_d   = cnt_q + 9'd1;
        state_d = last ? S_DONE : (oor_q ? S_RPUSH : S_RFETCH);
      end
      S_WADDR: state_d = S_WCAP;
      S_WCAP: begin
        data_d = sd_buff_din;
`ifdef SDRESP_WRITE_EN
        if (!oor_q) begin
          state_d = S_WSTORE;
        end else begin
          cnt_d   = cnt_q + 9'd1;
          state_d = last ? S_DONE : S_WADDR;
        end
`else
        cnt_d   = cnt_q + 9'd1;
        state_d = last ? S_DONE : S_WADDR;
`endif
      end
      S_WSTORE: begin
        if (mem_ack) begin
          cnt_d   = cnt_q + 9'd1;
          state_d = last ? S_DONE : S_WADDR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      secbase_q <= '0;
      oor_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      secbase_q <= secbase_d;
      oor_q     <= oor_d;
    end
  end

  // Outputs decode from registered state only, so a reset edge clears them all.
  always_comb begin
    busy         = (state_q != S_IDLE);
    sd_ack       = (state_q != S_IDLE) && (state_q != S_DONE);
    sd_buff_addr = cnt_q;
    sd_buff_wr   = (state_q == S_RPUSH);
    sd_buff_dout = (state_q == S_RPUSH) ? data_q : '0;
    mem_req      = (state_q == S_RFETCH) || (state_q == S_WSTORE);
    mem_addr     = mem_req ? (secbase_q + {23'd0, cnt_q}) : '0;
`ifdef SDRESP_WRITE_EN
    mem_we       = (state_q == S_WSTORE);
`else
    mem_we       = 1'b0;
`endif
    mem_wdata    = (state_q == S_WSTORE) ? data_q : '0;
    range_err    = (state_q == S_DONE) && oor_q;
  end

endmodule

// File: tb/tb_sd_img_responder.sv
module tb_sd_img_responder;

  localparam logic [31:0] B0 = 32'h0000_0000;
  localparam logic [31:0] B1 = 32'h0010_0000;
`ifdef SDRESP_WRITE_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [31:0] img_size0, img_size1, sd_lba;
  logic [1:0]  sd_rd, sd_wr;
  logic        sd_ack, sd_buff_wr, mem_req, mem_we, mem_ack, busy, range_err;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout, sd_buff_din, mem_wdata, mem_rdata;
  logic [31:0] mem_addr;
  logic [1:0]  lat, wcnt;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [16:0] rd_q[$];
  logic [39:0] wr_q[$];

  sd_img_responder #(.IMG_BASE0(B0), .IMG_BASE1(B1)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .img_size0(img_size0), .img_size1(img_size1), .sd_lba(sd_lba),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .range_err(range_err)
  );

  always #5 clk_sys = ~clk_sys;

  // Image memory: content is a function of address; ack after lat wait cycles.
  assign mem_rdata = mem_addr[7:0] ^ 8'h5A;
  assign mem_ack   = mem_req && (wcnt == lat);
  always_ff @(posedge clk_sys) wcnt <= (mem_req && !mem_ack) ? wcnt + 2'd1 : 2'd0;

  // Sector buffer: byte value equals its index, one cycle of read latency.
  always_ff @(posedge clk_sys) sd_buff_din <= sd_buff_addr[7:0];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller raises the request; this waits for accept, drops it, and scores the transfer.
  task automatic xfer(input string tag, input bit drv, input bit wr,
                      input logic [31:0] lba, input bit exp_imm);
    logic [31:0] sz, sec, a, first_addr, p_addr;
    logic [16:0] e17;
    logic [39:0] e40;
    logic [7:0]  p_wd;
    logic        p_we;
    bit          oor, use_mem, rerr, pend, got_first;
    int unsigned waited, acks, strobes, hs, bad_we, viol, exp_acks;
    sz      = drv ? img_size1 : img_size0;
    sec     = (drv ? B1 : B0) + (lba << 9);
    oor     = lba >= (sz >> 9);
    use_mem = !oor && (!wr || WR_EN);
    rerr    = wr ? (oor || !WR_EN) : oor;
    if (!wr) exp_acks = oor ? 512 : 512 * (2 + int'(lat));
    else     exp_acks = use_mem ? 512 * (3 + int'(lat)) : 1024;
    for (int unsigned i = 0; i < 512; i++) begin
      a = sec + i;
      if (!wr) rd_q.push_back({i[8:0], oor ? 8'h00 : (a[7:0] ^ 8'h5A)});
      else if (use_mem) wr_q.push_back({a, i[7:0]});
    end
    waited = 0;
    do begin @(negedge clk_sys); waited++; end while (!sd_ack && waited < 64);
    chk({tag, " accepted"}, 64'(sd_ack), 64'd1);
    if (exp_imm) begin
      chk({tag, " ack latency"}, 64'(waited), 64'd1);
      chk({tag, " busy at accept"}, 64'(busy), 64'd1);
    end
    if (wr) sd_wr[drv] = 1'b0; else sd_rd[drv] = 1'b0;
    acks = 0; strobes = 0; hs = 0; bad_we = 0; viol = 0;
    pend = 0; got_first = 0; first_addr = '0; p_addr = '0; p_we = 0; p_wd = '0;
    while (sd_ack && acks < 8000) begin
      acks++;
      if (sd_buff_wr) begin
        strobes++;
        chk({tag, " strobe expected"}, 64'(rd_q.size() != 0), 64'd1);
        if (rd_q.size() != 0) begin
          e17 = rd_q.pop_front();
          chk({tag, " strobe addr/data"}, 64'({sd_buff_addr, sd_buff_dout}), 64'(e17));
        end
      end
      if (mem_req) begin
        if (!got_first) begin first_addr = mem_addr; got_first = 1; end
        if (mem_we !== wr) bad_we++;
        if (pend && (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wd)) viol++;
        if (mem_ack) begin
          hs++;
          if (mem_we) begin
            chk({tag, " store expected"}, 64'(wr_q.size() != 0), 64'd1);
            if (wr_q.size() != 0) begin
              e40 = wr_q.pop_front();
              chk({tag, " store addr/data"}, 64'({mem_addr, mem_wdata}), 64'(e40));
            end
          end
        end
      end
      pend = mem_req && !mem_ack; p_addr = mem_addr; p_we = mem_we; p_wd = mem_wdata;
      @(negedge clk_sys);
    end
    chk({tag, " ack cycles"}, 64'(acks), 64'(exp_acks));
    chk({tag, " range_err at DONE"}, 64'(range_err), 64'(rerr));
    chk({tag, " busy at DONE"}, 64'(busy), 64'd1);
    chk({tag, " strobe count"}, 64'(strobes), wr ? 64'd0 : 64'd512);
    chk({tag, " mem handshakes"}, 64'(hs), use_mem ? 64'd512 : 64'd0);
    chk({tag, " mem_we on requests"}, 64'(bad_we), 64'd0);
    chk({tag, " mem request stable"}, 64'(viol), 64'd0);
    if (use_mem) chk({tag, " first mem_addr"}, 64'(first_addr), 64'(sec));
    chk({tag, " scoreboard drained"}, 64'(rd_q.size() + wr_q.size()), 64'd0);
    @(negedge clk_sys);
    chk({tag, " range_err one cycle"}, 64'(range_err), 64'd0);
    chk({tag, " idle after DONE"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          found;
    int unsigned reqs;
    reset_n = 1'b0; sd_rd = '0; sd_wr = '0; sd_lba = '0; lat = 2'd0;
    img_size0 = 32'd4096; img_size1 = 32'h0002_0000;
    repeat (3) @(negedge clk_sys);
    chk("reset outputs", 64'({sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_req, mem_we,
                              mem_addr, mem_wdata, busy, range_err}), 64'd0);
    reset_n = 1'b1;
    @(negedge clk_sys);
    chk("idle after reset", 64'(busy), 64'd0);

    // Read drive 0, LBA 3: first memory address 0x600.
    sd_lba = 32'd3; sd_rd = 2'b01;
    xfer("rd0 lba3", 1'b0, 1'b0, 32'd3, 1'b1);

    // Write drive 1, LBA 0.
    sd_lba = 32'd0; sd_wr = 2'b10;
    xfer("wr1 lba0", 1'b1, 1'b1, 32'd0, 1'b1);

    // Simultaneous requests served in priority order, one wait state on memory.
    lat = 2'd1; sd_lba = 32'd2; sd_rd = 2'b11; sd_wr = 2'b01;
    xfer("arb rd0", 1'b0, 1'b0, 32'd2, 1'b1);
    xfer("arb wr0", 1'b0, 1'b1, 32'd2, 1'b0);
    xfer("arb rd1", 1'b1, 1'b0, 32'd2, 1'b0);
    lat = 2'd0;

    // Range boundary: LBA 7 is the last sector of a 4096-byte image, LBA 8 is past it.
    sd_lba = 32'd7; sd_rd = 2'b01;
    xfer("rd0 lba7", 1'b0, 1'b0, 32'd7, 1'b1);
    sd_lba = 32'd8; sd_rd = 2'b01;
    xfer("rd0 lba8 oor", 1'b0, 1'b0, 32'd8, 1'b1);

    // Zero-size image: every LBA out of range.
    img_size1 = 32'd0; sd_lba = 32'd0; sd_rd = 2'b10;
    xfer("rd1 size0", 1'b1, 1'b0, 32'd0, 1'b1);
    img_size1 = 32'h0002_0000;

    // Reset at byte 100 of a read.
    sd_lba = 32'd3; sd_rd = 2'b01; found = 0;
    for (int k = 0; k < 3000 && !found; k++) begin
      @(negedge clk_sys);
      if (sd_ack) sd_rd[0] = 1'b0;
      if (sd_buff_wr && sd_buff_addr == 9'd100) found = 1;
    end
    chk("reset: reached byte 100", 64'(found), 64'd1);
    reset_n = 1'b0;
    @(negedge clk_sys);
    chk("reset: sd_ack", 64'(sd_ack), 64'd0);
    chk("reset: mem_req", 64'(mem_req), 64'd0);
    chk("reset: busy", 64'(busy), 64'd0);
    chk("reset: all outputs", 64'({sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_req, mem_we,
                                   mem_addr, mem_wdata, busy, range_err}), 64'd0);
    reset_n = 1'b1;
    reqs = 0;
    repeat (4) begin @(negedge clk_sys); if (mem_req) reqs++; end
    chk("reset: no memory cycles", 64'(reqs), 64'd0);
    rd_q.delete(); wr_q.delete();
    sd_rd = 2'b01;
    xfer("rd0 after reset", 1'b0, 1'b0, 32'd3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
